alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: cycles from multiply issue to valid product on alu_out; legal range 1-15.
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation.
REQ-005 SHALL have ports reqN_ready  output  1  sequencer accepts requester N this cycle.
REQ-006 SHALL have ports reqN_op  input  3  ALU code: 0 add, 1 sub, 2 mul, 3 div, 4 inc, 5 dec, 6 cmp, 7 parity/hold.
REQ-007 SHALL have ports reqN_a, reqN_b  input  32 each  operands.
REQ-008 SHALL have port resp_valid  output  1  result held for requester.
REQ-009 SHALL have port resp_ready  input  1  consumer takes result.
REQ-010 SHALL have port resp_id  output  1  index of the requester owning the result.
REQ-011 SHALL have port resp_data  output  64  result; div: quotient [31:0], remainder [63:32].
REQ-012 SHALL have port resp_carry  output  1  carry from ops 0, 1, 4 and 5; 0 otherwise.
REQ-013 SHALL have port resp_err  output  1  divide by zero.
REQ-014 SHALL have port alu_cntrl  output  3  registered drive to ALU opcode.
REQ-015 SHALL have ports alu_src1, alu_src2  output  32 each  registered ALU operands.
REQ-016 SHALL have ports alu_out  input  64  and alu_carry  input  1  ALU registered result and carry.

Function
REQ-017 SHALL use FSM states IDLE, ISSUE, WAIT, CAPT, DIVCHK, RESP.
REQ-018 In IDLE, reqN_ready SHALL be 1 only for the arbitration winner, and only when that requester's valid is high; it is combinational from valid and arbiter state.
REQ-019 On accept at edge T, the sequencer SHALL latch op, a, b and id, drive alu_cntrl/src from edge T, and go to ISSUE.
REQ-020 For ops 0,1,4,5,6,7: ISSUE->CAPT; alu_out/alu_carry sampled at edge T+2 into resp_data/resp_carry; resp_valid=1 after edge T+2.
REQ-021 For op 2: the sequencer SHALL stay in WAIT for MUL_LAT-1 cycles, then CAPT; resp_valid=1 after edge T+1+MUL_LAT, with full 64-bit product.
REQ-022 For op 3 the sequencer SHALL divide unsigned by repeated subtraction, using ALU sub (code 1) only; no code 3 is ever issued.
REQ-023 Div: b==0 -> RESP after edge T+1, resp_err=1, resp_data=0; otherwise rem=a, q=0, DIVCHK.
REQ-024 DIVCHK: rem<b -> RESP with {rem,q}; else issue sub(rem,b), capture alu_out[31:0] into rem 2 cycles later, q=q+1, return to DIVCHK; 3 cycles per iteration.
REQ-025 a<b (including a=0) SHALL give q=0, rem=a, no subtraction issued.
REQ-026 RESP SHALL hold all resp_* stable while resp_ready=0; on resp_valid&resp_ready go IDLE, clearing resp_valid the same edge.
REQ-027 No new request SHALL be accepted until the cycle after the response handshake (one operation outstanding).
REQ-028 Outside ISSUE/sub-issue cycles, alu_cntrl SHALL be 7 with alu_src1/alu_src2 holding last values.
REQ-029 Op 7 response SHALL carry alu_out as sampled (ALU hold value), resp_carry=0.

Reset
REQ-030 On Reset low, immediately: state IDLE, reqN_ready 0, resp_valid 0, resp_id 0, resp_data 0, resp_carry 0, resp_err 0, alu_cntrl 7, alu_src1/alu_src2 0, q/rem 0, priority pointer to requester 0.
REQ-031 Reset asserted mid-operation (including mid-divide) SHALL abandon it with no response; first accept possible on the first rising edge after release.

Configuration
REQ-032 With ALU_SEQ_RR_EN defined, arbitration SHALL be round-robin: on contention the requester not granted last wins; the pointer updates only on accept.
REQ-033 Without ALU_SEQ_RR_EN, requester 0 SHALL always win contention, and the pointer logic is absent.

Verification
REQ-034 req0 add a=0xFFFFFFFF, b=1 -> resp_data=0, resp_carry=1, resp_id=0, resp_valid 2 cycles after accept.
REQ-035 req1 mul a=0x10000, b=0x10000, MUL_LAT=2 -> resp_data=0x0000000100000000 after 3 cycles.
REQ-036 div a=17, b=5 -> q=3, rem=2, resp_data=0x0000000200000003, resp_valid 11 cycles after accept; div a=3, b=0 -> resp_err=1, resp_data=0.
REQ-037 Both valid continuously, RR_EN defined -> grants alternate 0,1,0,1; undefined -> all grants to 0.
REQ-038 resp_ready held 0 for 5 cycles -> resp_* stable, both reqN_ready 0; Reset low mid-divide (a=100, b=1) -> all outputs at reset values, no response.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer, its two requesters, the response consumer and the external ALU.
// A valid/ready transfer happens on a rising edge where both are high; valid holds its payload until then.
interface alu_sequencer_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [63:0] resp_data;
    logic        resp_carry;
    logic        resp_err;
    logic [2:0]  alu_cntrl;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [63:0] alu_out;
    logic        alu_carry;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready, alu_out, alu_carry,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_carry, resp_err,
        output alu_cntrl, alu_src1, alu_src2
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready, alu_out, alu_carry,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_carry, resp_err,
        input  alu_cntrl, alu_src1, alu_src2
    );
endinterface

// File: rtl/alu_sequencer.sv
// Two-requester sequencer driving a registered external ALU; divide runs as repeated ALU subtraction.
// Define ALU_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sequencer #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    alu_sequencer_if.slave bus,
    output logic [2:0]     o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        CAPT   = 3'd3,
        DIVCHK = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_INC  = 3'd4;
    localparam logic [2:0] OP_DEC  = 3'd5;
    localparam logic [2:0] OP_HOLD = 3'd7;
    localparam logic [3:0] MUL_WAIT = 4'(MUL_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_id;
    logic        r_div;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [3:0]  r_wait_cnt;
    logic        r_resp_valid;
    logic        r_resp_id;
    logic [63:0] r_resp_data;
    logic        r_resp_carry;
    logic        r_resp_err;
    logic [2:0]  r_alu_cntrl;
    logic [31:0] r_alu_src1;
    logic [31:0] r_alu_src2;

    logic        w_idle;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic        w_acc_id;
    logic [2:0]  w_acc_op;
    logic [31:0] w_acc_a;
    logic [31:0] w_acc_b;
    logic        w_carry_op;
    logic        w_issue_sub;
    logic        w_div_start;
    logic        w_div_err;
    logic        w_div_step;
    logic        w_div_done;
    logic        w_capt;
    logic        w_resp_take;

    // Ready is gated by Reset so nothing looks accepted while reset is held.
    assign w_idle = (r_state == IDLE) && Reset;

`ifdef ALU_SEQ_RR_EN
    logic r_prio;

    assign w_ready0 = w_idle && bus.req0_valid && (!bus.req1_valid || !r_prio);
    assign w_ready1 = w_idle && bus.req1_valid && (!bus.req0_valid || r_prio);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_acc_id;
        end
    end
`else
    assign w_ready0 = w_idle && bus.req0_valid;
    assign w_ready1 = w_idle && bus.req1_valid && !bus.req0_valid;
`endif

    assign w_accept   = w_ready0 || w_ready1;
    assign w_acc_id   = w_ready1;
    assign w_acc_op   = w_ready1 ? bus.req1_op : bus.req0_op;
    assign w_acc_a    = w_ready1 ? bus.req1_a  : bus.req0_a;
    assign w_acc_b    = w_ready1 ? bus.req1_b  : bus.req0_b;
    assign w_carry_op = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                        (r_op == OP_INC) || (r_op == OP_DEC);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // While r_div is set, ISSUE/CAPT carry the divide's internal subtraction.
    always_comb begin
        w_next      = r_state;
        w_issue_sub = 1'b0;
        w_div_start = 1'b0;
        w_div_err   = 1'b0;
        w_div_step  = 1'b0;
        w_div_done  = 1'b0;
        w_capt      = 1'b0;
        w_resp_take = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = ISSUE;
            end
            ISSUE: begin
                if (r_div) begin
                    w_next = CAPT;
                end else if (r_op == OP_DIV) begin
                    if (r_b == 32'd0) begin
                        w_next    = RESP;
                        w_div_err = 1'b1;
                    end else begin
                        w_next      = DIVCHK;
                        w_div_start = 1'b1;
                    end
                end else if ((r_op == OP_MUL) && (MUL_LAT > 1)) begin
                    w_next = WAIT;
                end else begin
                    w_next = CAPT;
                end
            end
            WAIT: begin
                if (r_wait_cnt <= 4'd1) w_next = CAPT;
            end
            CAPT: begin
                if (r_div) begin
                    w_next     = DIVCHK;
                    w_div_step = 1'b1;
                end else begin
                    w_next = RESP;
                    w_capt = 1'b1;
                end
            end
            DIVCHK: begin
                if (r_rem < r_b) begin
                    w_next     = RESP;
                    w_div_done = 1'b1;
                end else begin
                    w_next      = ISSUE;
                    w_issue_sub = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_next      = IDLE;
                    w_resp_take = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_op         <= 3'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_id         <= 1'b0;
            r_div        <= 1'b0;
            r_rem        <= 32'd0;
            r_q          <= 32'd0;
            r_wait_cnt   <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= 64'd0;
            r_resp_carry <= 1'b0;
            r_resp_err   <= 1'b0;
            r_alu_cntrl  <= OP_HOLD;
            r_alu_src1   <= 32'd0;
            r_alu_src2   <= 32'd0;
        end else begin
            r_alu_cntrl <= OP_HOLD;
            if (w_accept) begin
                r_op        <= w_acc_op;
                r_a         <= w_acc_a;
                r_b         <= w_acc_b;
                r_id        <= w_acc_id;
                r_alu_cntrl <= (w_acc_op == OP_DIV) ? OP_HOLD : w_acc_op;
                r_alu_src1  <= w_acc_a;
                r_alu_src2  <= w_acc_b;
            end
            if (w_issue_sub) begin
                r_alu_cntrl <= OP_SUB;
                r_alu_src1  <= r_rem;
                r_alu_src2  <= r_b;
            end
            if (r_state == ISSUE) begin
                r_wait_cnt <= MUL_WAIT;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_div_start) begin
                r_div <= 1'b1;
                r_rem <= r_a;
                r_q   <= 32'd0;
            end
            if (w_div_step) begin
                r_rem <= bus.alu_out[31:0];
                r_q   <= r_q + 32'd1;
            end
            if (w_div_done) begin
                r_div        <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_resp_data  <= {r_rem, r_q};
                r_resp_carry <= 1'b0;
                r_resp_err   <= 1'b0;
            end
            if (w_div_err) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_resp_data  <= 64'd0;
                r_resp_carry <= 1'b0;
                r_resp_err   <= 1'b1;
            end
            if (w_capt) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_resp_data  <= bus.alu_out;
                r_resp_carry <= w_carry_op ? bus.alu_carry : 1'b0;
                r_resp_err   <= 1'b0;
            end
            if (w_resp_take) r_resp_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_carry = r_resp_carry;
    assign bus.resp_err   = r_resp_err;
    assign bus.alu_cntrl  = r_alu_cntrl;
    assign bus.alu_src1   = r_alu_src1;
    assign bus.alu_src2   = r_alu_src2;
    assign o_dbg_state    = r_state;

endmodule
